matrix_c_row_writer: RTL and testbench
======================================

// Module: matrix_c_row_writer
// PURPOSE
//  Downstream stage of matrix_multiply: accepts one completed result row of C
//  (SIZE_COUNT words, one write pulse) and serialises it into word writes on
//  the matrix-C memory port. A BUF_ROWS-deep row FIFO absorbs bursts; a
//  write-ready handshake on the memory side tolerates a stalling memory.
// PARAMETERS
//  SIZE_COUNT  8   max matrix dimension, i.e. words per result row
//  ADDR_WIDTH  32  byte-address width of C memory
//  DATA_WIDTH  32  element/word width (multiple of 8)
//  BUF_ROWS    2   row FIFO depth (power of two, >=2)
//  localparam SIZE_WIDTH = $clog2(SIZE_COUNT)+1 (must hold value SIZE_COUNT)
// PORTS
//  clk             in   1              single clock, rising edge
//  reset           in   1              asynchronous, active-low reset
//  row_write       in   1              row_* valid; push when row_ready=1
//  row_ready       out  1              FIFO not full (registered)
//  row_address     in   ADDR_WIDTH     byte address of column 0 of row
//  row_cols        in   SIZE_WIDTH     valid columns in row (1..SIZE_COUNT)
//  row_data        in   DATA_WIDTH x SIZE_COUNT  unpacked array, [0]=column 0
//  mem_write       out  1              write request to C memory
//  mem_ready       in   1              memory accepts write this cycle
//  mem_address     out  ADDR_WIDTH     byte address of current word
//  mem_write_data  out  DATA_WIDTH     current word
//  mem_write_strb  out  DATA_WIDTH/8   all ones while mem_write=1, else 0
//  busy            out  1              FIFO non-empty or state WRITE
//  overflow        out  1              sticky: a row was offered while full
// BEHAVIOUR
//  Reset (reset=0, asynchronous): FIFO empty, state IDLE, row_ready=1,
//   mem_write=0, mem_address=0, mem_write_data=0, mem_write_strb=0, busy=0,
//   overflow=0. Reset mid-row discards all pending and in-flight rows.
//  Push: row_write & row_ready at edge -> row_address/row_cols/row_data stored.
//   row_ready = (count != BUF_ROWS), from registered count only; a pop in the
//   same cycle does NOT make room for a push when full.
//  row_write & !row_ready -> row dropped, overflow set (cleared by reset only).
//  row_cols = 0 or > SIZE_COUNT is clamped to SIZE_COUNT.
//  FSM, 2 states:
//   IDLE : mem_write=0. If FIFO non-empty -> WRITE, col=0 (head row latched).
//   WRITE: mem_write=1, mem_address = head.address + col*(DATA_WIDTH/8)
//          (mod 2^ADDR_WIDTH, wraps), mem_write_data = head.data[col].
//          Outputs held stable while mem_ready=0.
//          mem_write & mem_ready: col==cols-1 -> pop head, -> IDLE;
//          else col++ and stay in WRITE.
//  Latency: row pushed at edge N -> first mem_write=1 in cycle after edge N+1;
//   with mem_ready=1 a row of k words occupies k cycles, then 1 IDLE bubble.
//  Simultaneous push and pop: both take effect; count unchanged.
//  FIFO pointers wrap modulo BUF_ROWS; empty/full from count, not pointers.
//  busy deasserts the cycle after the last word's handshake if FIFO empty.
//  Outputs other than mem_write/strb are don't-care-free: driven 0 in IDLE.
// TESTING
//  1 single row: SIZE_COUNT=8, addr=0x100, cols=8, data=k+1, mem_ready=1 ->
//    8 writes to 0x100..0x11C data 1..8, first write 2 cycles after push.
//  2 partial row: cols=3, addr=0x40 -> exactly 3 writes 0x40,0x44,0x48; cols=0
//    -> 8 writes (clamp).
//  3 backpressure: mem_ready toggles 1,0,0,1... -> address/data stable while
//    stalled, no word skipped or duplicated, 8 writes total.
//  4 burst/overflow: 3 back-to-back rows, mem_ready=0 -> rows 1-2 accepted,
//    row_ready=0, row 3 dropped, overflow=1; release -> 16 writes in order.
//  5 push while full and popping last word -> push refused (row_ready=0 that
//    cycle), overflow=1 if row_write held; count stays consistent.
//  6 reset asserted mid-row (col=4) -> all outputs 0 asynchronously, no further
//    writes after release, row_ready=1, busy=0, overflow=0.

Source files
------------

// File: rtl/matrix_c_row_writer_if.sv
// Row-in / word-out bus of the matrix-C row writer.
// The slave modport is the writer's view; the master modport is the view of
// whatever drives the rows and plays the C memory.
interface matrix_c_row_writer_if #(
  parameter int unsigned SIZE_COUNT = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned SIZE_WIDTH = $clog2(SIZE_COUNT) + 1;

  // Row side
  logic                  row_write;
  logic                  row_ready;
  logic [ADDR_WIDTH-1:0] row_address;
  logic [SIZE_WIDTH-1:0] row_cols;
  logic [DATA_WIDTH-1:0] row_data [SIZE_COUNT];

  // Memory side
  logic                    mem_write;
  logic                    mem_ready;
  logic [ADDR_WIDTH-1:0]   mem_address;
  logic [DATA_WIDTH-1:0]   mem_write_data;
  logic [DATA_WIDTH/8-1:0] mem_write_strb;

  // Status
  logic busy;
  logic overflow;

  modport slave (
    input  row_write, row_address, row_cols, row_data, mem_ready,
    output row_ready, mem_write, mem_address, mem_write_data, mem_write_strb, busy, overflow
  );

  modport master (
    output row_write, row_address, row_cols, row_data, mem_ready,
    input  row_ready, mem_write, mem_address, mem_write_data, mem_write_strb, busy, overflow
  );
endinterface

// File: rtl/matrix_c_row_writer.sv
// Matrix-C row writer: buffers completed result rows in a small FIFO and
// serialises each into word writes on the C memory port, honouring mem_ready.
module matrix_c_row_writer #(
  parameter int unsigned SIZE_COUNT = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUF_ROWS   = 2
) (
  input logic                   clk,
  input logic                   reset,
  matrix_c_row_writer_if.slave  bus
);
  localparam int unsigned SIZE_WIDTH = $clog2(SIZE_COUNT) + 1;
  localparam int unsigned COL_IDX_W  = (SIZE_COUNT > 1) ? $clog2(SIZE_COUNT) : 1;
  localparam int unsigned PTR_W      = $clog2(BUF_ROWS);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam int unsigned BYTES      = DATA_WIDTH / 8;

  typedef enum logic {StIdle, StWrite} state_e;

  state_e                state_q, state_d;
  logic [SIZE_WIDTH-1:0] col_q, col_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  overflow_q;

  // Row storage; contents need no reset since count gates every read
  logic [ADDR_WIDTH-1:0] addr_mem [BUF_ROWS];
  logic [SIZE_WIDTH-1:0] cols_mem [BUF_ROWS];
  logic [DATA_WIDTH-1:0] data_mem [BUF_ROWS][SIZE_COUNT];

  logic                  full, empty, push, pop, last_col;
  logic [SIZE_WIDTH-1:0] cols_clamped;
  logic [SIZE_WIDTH-1:0] head_cols;

  // Readiness comes from the registered count only, so a same-cycle pop never frees a slot
  assign full      = (count_q == CNT_W'(BUF_ROWS));
  assign empty     = (count_q == '0);
  assign push      = bus.row_write && !full;
  assign head_cols = cols_mem[rd_ptr_q];
  assign last_col  = (col_q == head_cols - SIZE_WIDTH'(1));

  assign bus.row_ready = !full;
  assign bus.busy      = !empty || (state_q == StWrite);
  assign bus.overflow  = overflow_q;

  // Out-of-range column counts mean a full row
  always_comb begin
    cols_clamped = bus.row_cols;
    if (bus.row_cols == '0 || bus.row_cols > SIZE_WIDTH'(SIZE_COUNT)) begin
      cols_clamped = SIZE_WIDTH'(SIZE_COUNT);
    end
  end

  // Row storage write port
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= bus.row_address;
      cols_mem[wr_ptr_q] <= cols_clamped;
      for (int k = 0; k < SIZE_COUNT; k++) begin
        data_mem[wr_ptr_q][k] <= bus.row_data[k];
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
      if (bus.row_write && full) overflow_q <= 1'b1;
    end
  end

  // FSM state and column register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
    end
  end

  // Next state, pop and memory-port outputs; everything is zero outside StWrite
  always_comb begin
    state_d            = state_q;
    col_d              = col_q;
    pop                = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    bus.mem_write_strb = '0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d = StWrite;
          col_d   = '0;
        end
      end
      StWrite: begin
        bus.mem_write      = 1'b1;
        bus.mem_address    = addr_mem[rd_ptr_q] + ADDR_WIDTH'(col_q) * ADDR_WIDTH'(BYTES);
        bus.mem_write_data = data_mem[rd_ptr_q][col_q[COL_IDX_W-1:0]];
        bus.mem_write_strb = '1;
        if (bus.mem_ready) begin
          if (last_col) begin
            pop     = 1'b1;
            state_d = StIdle;
            col_d   = '0;
          end else begin
            col_d = col_q + SIZE_WIDTH'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end
endmodule

// File: tb/tb_matrix_c_row_writer.sv
// Directed bench for matrix_c_row_writer: single/partial rows, backpressure,
// burst overflow, push-while-full-and-popping, and reset in the middle of a row.
module tb_matrix_c_row_writer;
  localparam int unsigned SIZE_COUNT = 8;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BUF_ROWS   = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  matrix_c_row_writer_if #(
    .SIZE_COUNT(SIZE_COUNT), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) bus ();

  matrix_c_row_writer #(
    .SIZE_COUNT(SIZE_COUNT), .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .BUF_ROWS(BUF_ROWS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Log each word that will be accepted at the coming rising edge
  always @(negedge clk) begin
    if (reset && bus.mem_write && bus.mem_ready) begin
      wa_q.push_back(bus.mem_address);
      wd_q.push_back(bus.mem_write_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_row(input logic [31:0] addr, input logic [3:0] cols,
                         input logic [31:0] base);
    bus.row_address = addr;
    bus.row_cols    = cols;
    for (int k = 0; k < SIZE_COUNT; k++) bus.row_data[k] = base + 32'(k);
  endtask

  task automatic push_row(input logic [31:0] addr, input logic [3:0] cols,
                          input logic [31:0] base);
    @(posedge clk); #1;
    set_row(addr, cols, base);
    bus.row_write = 1'b1;
    @(posedge clk); #1;
    bus.row_write = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    bus.row_write = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.row_write = 1'b0;
    bus.mem_ready = 1'b1;
    set_row(32'h0, 4'd8, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.row_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_row_ready got %b want 1", bus.row_ready); end
    n_checks++; if (bus.mem_write !== 1'b0) begin n_fail++;
      $display("FAIL reset_mem_write got %b want 0", bus.mem_write); end
    n_checks++; if (bus.mem_address !== 32'h0) begin n_fail++;
      $display("FAIL reset_mem_address got %h want 0", bus.mem_address); end
    n_checks++; if (bus.mem_write_data !== 32'h0) begin n_fail++;
      $display("FAIL reset_mem_data got %h want 0", bus.mem_write_data); end
    n_checks++; if (bus.mem_write_strb !== 4'h0) begin n_fail++;
      $display("FAIL reset_strb got %h want 0", bus.mem_write_strb); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++;
      $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_single_row();
    int base = wa_q.size();
    bit ok;
    bus.mem_ready = 1'b1;
    push_row(32'h100, 4'd8, 32'd1);
    @(negedge clk);
    n_checks++; if (bus.mem_write !== 1'b0 || bus.busy !== 1'b1) begin n_fail++;
      $display("FAIL single_latency_idle got write=%b busy=%b want 0/1", bus.mem_write, bus.busy); end
    @(negedge clk);
    n_checks++; if (bus.mem_write !== 1'b1 || bus.mem_address !== 32'h100) begin n_fail++;
      $display("FAIL single_first_write got write=%b addr=%h want 1/100",
               bus.mem_write, bus.mem_address); end
    n_checks++; if (bus.mem_write_strb !== 4'hF || bus.mem_write_data !== 32'd1) begin n_fail++;
      $display("FAIL single_first_word got strb=%h data=%h want f/1",
               bus.mem_write_strb, bus.mem_write_data); end
    wait_idle(40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_idle timeout got busy want idle"); end
    n_checks++; if (wa_q.size() - base != 8) begin n_fail++;
      $display("FAIL single_count got %0d want 8", wa_q.size() - base); end
    for (int k = 0; k < 8 && base + k < wa_q.size(); k++) begin
      n_checks++;
      if (wa_q[base+k] !== 32'h100 + 32'(4*k) || wd_q[base+k] !== 32'(k + 1)) begin n_fail++;
        $display("FAIL single_word%0d got %h/%h want %h/%h", k, wa_q[base+k], wd_q[base+k],
                 32'h100 + 32'(4*k), 32'(k + 1)); end
    end
  endtask

  task automatic test_partial_row();
    int base = wa_q.size();
    bit ok;
    push_row(32'h40, 4'd3, 32'hA0);
    wait_idle(40, ok);
    n_checks++; if (!ok || wa_q.size() - base != 3) begin n_fail++;
      $display("FAIL partial_count got %0d want 3", wa_q.size() - base); end
    for (int k = 0; k < 3 && base + k < wa_q.size(); k++) begin
      n_checks++;
      if (wa_q[base+k] !== 32'h40 + 32'(4*k) || wd_q[base+k] !== 32'hA0 + 32'(k)) begin n_fail++;
        $display("FAIL partial_word%0d got %h/%h want %h/%h", k, wa_q[base+k], wd_q[base+k],
                 32'h40 + 32'(4*k), 32'hA0 + 32'(k)); end
    end
    base = wa_q.size();
    push_row(32'h200, 4'd0, 32'hB0);
    wait_idle(40, ok);
    n_checks++; if (!ok || wa_q.size() - base != 8) begin n_fail++;
      $display("FAIL clamp_count got %0d want 8", wa_q.size() - base); end
    if (wa_q.size() - base == 8) begin
      n_checks++;
      if (wa_q[base+7] !== 32'h21C || wd_q[base+7] !== 32'hB7) begin n_fail++;
        $display("FAIL clamp_last got %h/%h want 21c/b7", wa_q[base+7], wd_q[base+7]); end
    end
  endtask

  task automatic test_backpressure();
    int base = wa_q.size();
    bit prev_stall = 1'b0;
    bit done = 1'b0;
    logic [31:0] pa = '0;
    logic [31:0] pd = '0;
    bus.mem_ready = 1'b0;
    push_row(32'h300, 4'd8, 32'h30);
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge clk); #1;
      bus.mem_ready = (cyc % 3 == 0);
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if (bus.mem_write !== 1'b1 || bus.mem_address !== pa || bus.mem_write_data !== pd) begin
          n_fail++;
          $display("FAIL stall_hold got %b/%h/%h want 1/%h/%h", bus.mem_write,
                   bus.mem_address, bus.mem_write_data, pa, pd); end
      end
      prev_stall = bus.mem_write && !bus.mem_ready;
      pa = bus.mem_address;
      pd = bus.mem_write_data;
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
    end
    bus.mem_ready = 1'b1;
    n_checks++; if (!done || wa_q.size() - base != 8) begin n_fail++;
      $display("FAIL stall_count got %0d want 8", wa_q.size() - base); end
    for (int k = 0; k < 8 && base + k < wa_q.size(); k++) begin
      n_checks++;
      if (wa_q[base+k] !== 32'h300 + 32'(4*k) || wd_q[base+k] !== 32'h30 + 32'(k)) begin n_fail++;
        $display("FAIL stall_word%0d got %h/%h want %h/%h", k, wa_q[base+k], wd_q[base+k],
                 32'h300 + 32'(4*k), 32'h30 + 32'(k)); end
    end
  endtask

  task automatic test_burst_overflow();
    int base = wa_q.size();
    bit ok;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    set_row(32'h1000, 4'd8, 32'h10); bus.row_write = 1'b1;
    @(posedge clk); #1;
    set_row(32'h2000, 4'd8, 32'h20);
    @(posedge clk); #1;
    set_row(32'h3000, 4'd8, 32'h30);
    @(negedge clk);
    n_checks++; if (bus.row_ready !== 1'b0) begin n_fail++;
      $display("FAIL burst_full got row_ready=%b want 0", bus.row_ready); end
    @(posedge clk); #1 bus.row_write = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++;
      $display("FAIL burst_overflow got %b want 1", bus.overflow); end
    n_checks++; if (bus.mem_write !== 1'b1 || bus.mem_address !== 32'h1000) begin n_fail++;
      $display("FAIL burst_stalled got %b/%h want 1/1000", bus.mem_write, bus.mem_address); end
    bus.mem_ready = 1'b1;
    wait_idle(80, ok);
    n_checks++; if (!ok || wa_q.size() - base != 16) begin n_fail++;
      $display("FAIL burst_count got %0d want 16", wa_q.size() - base); end
    for (int k = 0; k < 16 && base + k < wa_q.size(); k++) begin
      logic [31:0] ea, ed;
      ea = (k < 8 ? 32'h1000 : 32'h2000) + 32'(4 * (k % 8));
      ed = (k < 8 ? 32'h10 : 32'h20) + 32'(k % 8);
      n_checks++;
      if (wa_q[base+k] !== ea || wd_q[base+k] !== ed) begin n_fail++;
        $display("FAIL burst_word%0d got %h/%h want %h/%h", k, wa_q[base+k], wd_q[base+k],
                 ea, ed); end
    end
  endtask

  task automatic test_push_while_popping();
    int base;
    bit ok;
    do_reset();
    base = wa_q.size();
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    set_row(32'h500, 4'd2, 32'h50); bus.row_write = 1'b1;
    @(posedge clk); #1;
    set_row(32'h600, 4'd1, 32'h60);
    @(posedge clk); #1;
    bus.row_write = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    set_row(32'h700, 4'd1, 32'h70); bus.row_write = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.row_ready !== 1'b0 || bus.mem_address !== 32'h504) begin n_fail++;
      $display("FAIL popfull_refuse got ready=%b addr=%h want 0/504",
               bus.row_ready, bus.mem_address); end
    @(posedge clk); #1 bus.row_write = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.overflow !== 1'b1 || bus.row_ready !== 1'b1) begin n_fail++;
      $display("FAIL popfull_after got ovf=%b ready=%b want 1/1", bus.overflow, bus.row_ready); end
    wait_idle(40, ok);
    n_checks++; if (!ok || wa_q.size() - base != 3) begin n_fail++;
      $display("FAIL popfull_count got %0d want 3", wa_q.size() - base); end
    if (wa_q.size() - base == 3) begin
      n_checks++;
      if (wa_q[base] !== 32'h500 || wa_q[base+1] !== 32'h504 || wa_q[base+2] !== 32'h600 ||
          wd_q[base+2] !== 32'h60) begin n_fail++;
        $display("FAIL popfull_order got %h,%h,%h want 500,504,600",
                 wa_q[base], wa_q[base+1], wa_q[base+2]); end
    end
    n_checks++; if (bus.row_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL popfull_drained got ready=%b busy=%b want 1/0", bus.row_ready, bus.busy); end
  endtask

  task automatic test_reset_mid_row();
    int n;
    bit found = 1'b0;
    bit saw_write = 1'b0;
    bus.mem_ready = 1'b1;
    push_row(32'h800, 4'd8, 32'h80);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_write && bus.mem_address == 32'h810) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL midrst_reach got none want col4"); end
    #1 reset = 1'b0;
    #1;
    n = wa_q.size();
    n_checks++;
    if (bus.mem_write !== 1'b0 || bus.mem_address !== 32'h0 || bus.mem_write_data !== 32'h0 ||
        bus.mem_write_strb !== 4'h0) begin n_fail++;
      $display("FAIL midrst_async got %b/%h/%h/%h want all 0", bus.mem_write,
               bus.mem_address, bus.mem_write_data, bus.mem_write_strb); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_write) saw_write = 1'b1;
    end
    n_checks++; if (saw_write || wa_q.size() != n) begin n_fail++;
      $display("FAIL midrst_nowrite got write=%b extra=%0d want 0/0", saw_write, wa_q.size() - n); end
    n_checks++;
    if (bus.row_ready !== 1'b1 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin n_fail++;
      $display("FAIL midrst_state got ready=%b busy=%b ovf=%b want 1/0/0",
               bus.row_ready, bus.busy, bus.overflow); end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_partial_row();
    test_backpressure();
    test_burst_overflow();
    test_push_while_popping();
    test_reset_mid_row();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
